seg7_message_scanner: RTL
=========================

# seg7_message_scanner

Parametrised, self-scanning seven-segment message driver for the traffic-light controller. It takes the registered NS/EW light codes and selects one of three fixed 8-character messages. It time-multiplexes that message across `NUM_DIGITS` common-anode digits using an internal refresh prescaler. It also supports scrolling, blinking while either light is yellow, and tear-free message switching at frame boundaries.

## Interface
Parameters:
- `NUM_DIGITS`, 8: physical digits driven, legal range 1..8.
- `REFRESH_DIV`, 100_000: clock cycles each digit stays lit.
- `SCROLL_FRAMES`, 64: frames between scroll steps.
- `BLINK_FRAMES`, 128: frames per blink half-period.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `Light_NS`  in  3  NS light: 3'b001 green, 3'b010 yellow, 3'b100 red; any other code is illegal.
- `Light_EW`  in  3  EW light, same encoding.
- `scroll_en`  in  1  1 = scroll the message left; 0 = static, offset held at 0.
- `cathode`  out  8  active-low segments, bit 7..0 = a,b,c,d,e,f,g,dp.
- `anode`  out  NUM_DIGITS  active-low digit enables; MSB = leftmost digit (digit 0).
- `msg_id`  out  2  latched message: 0 STOP_ALL, 1 NS_GO, 2 EW_GO.

## Operation
- Glyphs (cathode): G 8'b00001001, O 8'b11000101, S 8'b01001001, T 8'b11100001, P 8'b00110001, blank 8'hFF.
- Message decode:
  - NS_GO when NS=001 and EW=100: text "GO  STOP".
  - EW_GO when NS=100 and EW=001: text "STOP  GO".
  - All other combinations, including yellows and illegal codes: STOP_ALL, text "STOPSTOP".
- Message text is 8 characters, index 0..7.
- Prescaler counts 0..REFRESH_DIV-1 and issues a digit tick at REFRESH_DIV-1.
- Digit index counts 0..NUM_DIGITS-1 on each digit tick; a wrap from NUM_DIGITS-1 to 0 is the frame tick.
- Digit k lights anode bit NUM_DIGITS-1-k only, and shows character (k + offset) mod 8.
- Message latch: `msg_id` updates only on a frame tick, from the decode of the current inputs. When the value changes, offset and blink state are cleared in the same cycle.
- Scroll: while `scroll_en`=1, a frame counter advances offset by 1 mod 8 every SCROLL_FRAMES frames (offset 7 wraps to 0). While `scroll_en`=0, offset and its counter are held at 0.
- Blink:
  - Active when either light code equals 3'b010.
  - Phase toggles every BLINK_FRAMES frames, starting in the on phase.
  - Off phase drives anode all ones and cathode 8'hFF.
  - With no yellow present, the phase is forced on and its counter is cleared.
- Outputs are registered and always show exactly one digit or all-blank. No two anode bits are ever low together.

## Timing
- Reset values:
  - anode all ones, cathode 8'hFF, msg_id 0.
  - Prescaler, digit index, offset, scroll counter and blink counter all 0; blink phase on.
- Reset asserted mid-frame clears all state at the next edge; outputs are blank in the cycle after that edge.
- Outputs lag the internal digit index by one cycle.
- First edge with reset low: outputs show digit 0 of STOP_ALL ("S", anode MSB low).
- Each digit is held REFRESH_DIV cycles; a frame is NUM_DIGITS*REFRESH_DIV cycles.
- Input change to msg_id: at most one frame plus one cycle. Inputs are sampled only on the frame-tick cycle.
- Frame tick coinciding with a scroll step and a message change: the message change wins and offset becomes 0.
- All counters use widths of at least $clog2 of their terminal value and never overflow.

## Test plan
Bench parameters: NUM_DIGITS=8, REFRESH_DIV=4, SCROLL_FRAMES=2, BLINK_FRAMES=2 unless stated.
- Reset: hold `reset` for 3 cycles, then assert it again mid-frame -> anode 8'hFF, cathode 8'hFF, msg_id 0 on the next edge both times; then "S" on anode 8'b0111_1111 on the first free cycle.
- Static NS_GO (NS=001, EW=100) -> after the first frame tick msg_id=1. Per 4-cycle slot:
  - Digit 0: anode 0111_1111, cathode 00001001.
  - Digit 1: anode 1011_1111, cathode 11000101.
  - Digits 2-3: cathode 8'hFF.
  - Digit 4: anode 1111_0111, cathode 01001001.
  - Frame repeats every 32 cycles.
- Mid-frame change from NS_GO to EW_GO at cycle 10 of a frame -> msg_id stays 1 until the frame-tick cycle, then becomes 2. The next frame starts "S" on digit 0.
- Yellow (NS=010, EW=100) -> msg_id 0 and "STOPSTOP" for 64 cycles, then all-blank for 64 cycles, repeating. Setting NS=100 forces the display on within one cycle.
- Scroll, EW_GO with `scroll_en`=1 -> after 2 frames digit 0 shows "T" (11100001). After 16 frames offset is back to 0 and digit 0 shows "S". Dropping `scroll_en` restores offset 0 at once.
- NUM_DIGITS=4, NS_GO -> 4-bit anode cycling 0111, 1011, 1101, 1110 with "GO" then two blanks; frame is 16 cycles.

Source files
------------

// File: rtl/seg7_message_scanner.sv
// Self-scanning seven-segment message driver for the traffic-light controller.
// Multiplexes one of three 8-character messages across NUM_DIGITS common-anode digits.
module seg7_message_scanner #(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 100_000,
  parameter int SCROLL_FRAMES = 64,
  parameter int BLINK_FRAMES  = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            Light_NS,
  input  logic [2:0]            Light_EW,
  input  logic                  scroll_en,
  output logic [7:0]            cathode,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [1:0]            msg_id
);

  localparam int PW = (REFRESH_DIV   > 1) ? $clog2(REFRESH_DIV)   : 1;
  localparam int DW = (NUM_DIGITS    > 1) ? $clog2(NUM_DIGITS)    : 1;
  localparam int SW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int BW = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;

  localparam logic [7:0] GL_G     = 8'b0000_1001;
  localparam logic [7:0] GL_O     = 8'b1100_0101;
  localparam logic [7:0] GL_S     = 8'b0100_1001;
  localparam logic [7:0] GL_T     = 8'b1110_0001;
  localparam logic [7:0] GL_P     = 8'b0011_0001;
  localparam logic [7:0] GL_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    MSG_STOP_ALL = 2'd0,
    MSG_NS_GO    = 2'd1,
    MSG_EW_GO    = 2'd2
  } msg_e;

  // Character idx of each message: "STOPSTOP", "GO  STOP", "STOP  GO".
  function automatic logic [7:0] glyph_at(input msg_e msg, input logic [2:0] idx);
    logic [7:0] g;
    g = GL_BLANK;
    case (msg)
      MSG_NS_GO: begin
        case (idx)
          3'd0:    g = GL_G;
          3'd1:    g = GL_O;
          3'd4:    g = GL_S;
          3'd5:    g = GL_T;
          3'd6:    g = GL_O;
          3'd7:    g = GL_P;
          default: g = GL_BLANK;
        endcase
      end
      MSG_EW_GO: begin
        case (idx)
          3'd0:    g = GL_S;
          3'd1:    g = GL_T;
          3'd2:    g = GL_O;
          3'd3:    g = GL_P;
          3'd6:    g = GL_G;
          3'd7:    g = GL_O;
          default: g = GL_BLANK;
        endcase
      end
      default: begin
        case (idx[1:0])
          2'd0:    g = GL_S;
          2'd1:    g = GL_T;
          2'd2:    g = GL_O;
          default: g = GL_P;
        endcase
      end
    endcase
    return g;
  endfunction

  logic [PW-1:0]         r_presc;
  logic [DW-1:0]         r_digit;
  logic [2:0]            r_offset;
  logic [SW-1:0]         r_scroll_cnt;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_on;
  msg_e                  r_msg;
  logic [7:0]            r_cathode;
  logic [NUM_DIGITS-1:0] r_anode;

  logic                  w_digit_tick;
  logic                  w_frame_tick;
  logic                  w_yellow;
  logic                  w_msg_change;
  logic                  w_show;
  msg_e                  w_msg_dec;
  logic [2:0]            w_char_idx;
  logic [7:0]            w_glyph;
  logic [NUM_DIGITS-1:0] w_anode_sel;

  assign w_digit_tick = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_frame_tick = w_digit_tick && (r_digit == DW'(NUM_DIGITS - 1));
  assign w_yellow     = (Light_NS == 3'b010) || (Light_EW == 3'b010);
  assign w_msg_change = w_frame_tick && (w_msg_dec != r_msg);
  // Dropping the yellow un-blanks on the very next edge, not after the phase register catches up.
  assign w_show       = r_blink_on || !w_yellow;
  assign w_char_idx   = 3'(r_digit) + r_offset;
  assign w_glyph      = glyph_at(r_msg, w_char_idx);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    w_msg_dec = MSG_STOP_ALL;
    if (Light_NS == 3'b001 && Light_EW == 3'b100)
      w_msg_dec = MSG_NS_GO;
    else if (Light_NS == 3'b100 && Light_EW == 3'b001)
      w_msg_dec = MSG_EW_GO;
  end

  always_comb begin
    w_anode_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_anode_sel[i] = (r_digit != DW'(NUM_DIGITS - 1 - i));
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_digit      <= '0;
      r_offset     <= '0;
      r_scroll_cnt <= '0;
      r_blink_cnt  <= '0;
      r_blink_on   <= 1'b1;
      r_msg        <= MSG_STOP_ALL;
      r_anode      <= '1;
      r_cathode    <= GL_BLANK;
    end else begin
      if (w_digit_tick) begin
        r_presc <= '0;
        r_digit <= w_frame_tick ? '0 : r_digit + DW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (w_frame_tick)
        r_msg <= w_msg_dec;

      // A message change outranks a coincident scroll step.
      if (!scroll_en || w_msg_change) begin
        r_offset     <= '0;
        r_scroll_cnt <= '0;
      end else if (w_frame_tick) begin
        if (r_scroll_cnt == SW'(SCROLL_FRAMES - 1)) begin
          r_scroll_cnt <= '0;
          r_offset     <= r_offset + 3'd1;
        end else begin
          r_scroll_cnt <= r_scroll_cnt + SW'(1);
        end
      end

      if (!w_yellow || w_msg_change) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (w_frame_tick) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_blink_on  <= !r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end

      r_anode   <= w_show ? w_anode_sel : '1;
      r_cathode <= w_show ? w_glyph : GL_BLANK;
    end
  end

  assign anode   = r_anode;
  assign cathode = r_cathode;
  assign msg_id  = r_msg;

endmodule
